// File: rtl/lsj_rs.sv
// Reservation station and issue scheduler for the load/store/jalr address ALU.
// Captures the base operand from the CDB and issues one ready entry per cycle.
module lsj_rs #(
    parameter int RS_SIZE = 8,
    parameter int ROB_BIT = 4
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       clear_in,
    input  logic                       disp_valid,
    input  logic                       disp_op,
    input  logic [11:0]                disp_imm,
    input  logic                       disp_qj_busy,
    input  logic [ROB_BIT-1:0]         disp_qj,
    input  logic [31:0]                disp_vj,
    input  logic [ROB_BIT-1:0]         disp_rob,
    output logic                       full,
    input  logic                       cdb_valid,
    input  logic [ROB_BIT-1:0]         cdb_rob,
    input  logic [31:0]                cdb_value,
    output logic                       alu_valid,
    output logic [31:0]                alu_vi,
    output logic [11:0]                alu_imm,
    output logic                       alu_op,
    output logic [ROB_BIT-1:0]         alu_rob,
    output logic [$clog2(RS_SIZE):0]   occupancy
);
    localparam int IDX_W = $clog2(RS_SIZE);
    localparam int CNT_W = IDX_W + 1;

    logic [RS_SIZE-1:0] busy_q, busy_d;
    logic               op_q   [RS_SIZE];
    logic [11:0]        imm_q  [RS_SIZE];
    logic               qjb_q  [RS_SIZE];
    logic [ROB_BIT-1:0] qj_q   [RS_SIZE];
    logic [31:0]        vj_q   [RS_SIZE];
    logic [ROB_BIT-1:0] rob_q  [RS_SIZE];

    logic               alu_valid_q;
    logic [31:0]        alu_vi_q;
    logic [11:0]        alu_imm_q;
    logic               alu_op_q;
    logic [ROB_BIT-1:0] alu_rob_q;
    logic [CNT_W-1:0]   occ_q, occ_d;

    logic               issue_found;
    logic [IDX_W-1:0]   issue_idx, free_idx;
    logic               disp_acc, disp_fwd;

    assign full     = &busy_q;
    assign disp_acc = disp_valid && !full;
    assign disp_fwd = disp_qj_busy && cdb_valid && (cdb_rob == disp_qj);

    // Scanning downward leaves the lowest matching index in each encoder.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        issue_found = 1'b0;
        issue_idx   = '0;
        free_idx    = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (busy_q[i] && !qjb_q[i]) begin
                issue_found = 1'b1;
                issue_idx   = IDX_W'(i);
            end
            if (!busy_q[i]) free_idx = IDX_W'(i);
        end
    end

    // The issued slot is busy and the dispatch slot is free, so they never collide.
    always_comb begin
        busy_d = busy_q;
        if (issue_found) busy_d[issue_idx] = 1'b0;
        if (disp_acc)    busy_d[free_idx]  = 1'b1;
        occ_d = occ_q + CNT_W'(disp_acc) - CNT_W'(issue_found);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_in) begin
            busy_q      <= '0;
            alu_valid_q <= 1'b0;
            alu_vi_q    <= '0;
            alu_imm_q   <= '0;
            alu_op_q    <= 1'b0;
            alu_rob_q   <= '0;
            occ_q       <= '0;
        end else if (rdy_in) begin
            if (clear_in) begin
                busy_q      <= '0;
                alu_valid_q <= 1'b0;
                occ_q       <= '0;
            end else begin
                busy_q      <= busy_d;
                occ_q       <= occ_d;
                alu_valid_q <= issue_found;
                if (issue_found) begin
                    alu_vi_q  <= vj_q[issue_idx];
                    alu_imm_q <= imm_q[issue_idx];
                    alu_op_q  <= op_q[issue_idx];
                    alu_rob_q <= rob_q[issue_idx];
                end
            end
        end
    end

    // NOTE: entry payload is not reset; busy_q gates every use, so stale contents are harmless.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (cdb_valid && qjb_q[i] && (qj_q[i] == cdb_rob)) begin
                    qjb_q[i] <= 1'b0;
                    vj_q[i]  <= cdb_value;
                end
            end
            if (disp_acc && !clear_in) begin
                op_q[free_idx]  <= disp_op;
                imm_q[free_idx] <= disp_imm;
                qjb_q[free_idx] <= disp_qj_busy && !disp_fwd;
                qj_q[free_idx]  <= disp_qj;
                vj_q[free_idx]  <= disp_fwd ? cdb_value : disp_vj;
                rob_q[free_idx] <= disp_rob;
            end
        end
    end

    assign alu_valid = alu_valid_q;
    assign alu_vi    = alu_vi_q;
    assign alu_imm   = alu_imm_q;
    assign alu_op    = alu_op_q;
    assign alu_rob   = alu_rob_q;
    assign occupancy = occ_q;
endmodule

// File: tb/tb_lsj_rs.sv
// Directed bench for lsj_rs: reset, dispatch/issue, wakeup, forwarding,
// fill/ordering, flush and stall, all against hand-computed values.
module tb_lsj_rs;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear_in;
    logic        disp_valid, disp_op, disp_qj_busy;
    logic [11:0] disp_imm;
    logic [3:0]  disp_qj, disp_rob;
    logic [31:0] disp_vj;
    logic        full;
    logic        cdb_valid;
    logic [3:0]  cdb_rob;
    logic [31:0] cdb_value;
    logic        alu_valid, alu_op;
    logic [31:0] alu_vi;
    logic [11:0] alu_imm;
    logic [3:0]  alu_rob;
    logic [3:0]  occupancy;

    int n_vec = 0;
    int n_err = 0;

    lsj_rs #(.RS_SIZE(8), .ROB_BIT(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .disp_valid(disp_valid), .disp_op(disp_op), .disp_imm(disp_imm),
        .disp_qj_busy(disp_qj_busy), .disp_qj(disp_qj), .disp_vj(disp_vj),
        .disp_rob(disp_rob), .full(full),
        .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_value(cdb_value),
        .alu_valid(alu_valid), .alu_vi(alu_vi), .alu_imm(alu_imm),
        .alu_op(alu_op), .alu_rob(alu_rob), .occupancy(occupancy)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        rdy_in = 1'b1; clear_in = 1'b0; disp_valid = 1'b0; cdb_valid = 1'b0;
        disp_op = 1'b0; disp_imm = '0; disp_qj_busy = 1'b0; disp_qj = '0;
        disp_vj = '0; disp_rob = '0; cdb_rob = '0; cdb_value = '0;
    endtask

    task automatic set_disp(input logic op, input logic [11:0] imm, input logic qjb,
                            input logic [3:0] qj, input logic [31:0] vj, input logic [3:0] rob);
        disp_valid = 1'b1; disp_op = op; disp_imm = imm; disp_qj_busy = qjb;
        disp_qj = qj; disp_vj = vj; disp_rob = rob;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            set_disp(1'b0, 12'h0, 1'b1, 4'd9, 32'h0, 4'(i));
            tick();
        end
        set_disp(1'b1, 12'h0AB, 1'b0, 4'd0, 32'h0000_ABCD, 4'd7);
        tick();
        idle();
        tick();
        n_vec++; if (alu_valid !== 1'b1 || alu_vi !== 32'h0000_ABCD) begin n_err++;
            $display("FAIL pre_reset_issue: valid=%b vi=%h, want 1 0000abcd", alu_valid, alu_vi); end
        n_vec++; if (occupancy !== 4'd3) begin n_err++;
            $display("FAIL pre_reset_occ: got %0d want 3", occupancy); end
        rst_in = 1'b0;
        #1;
        n_vec++; if (occupancy !== 4'd0) begin n_err++;
            $display("FAIL reset_occ: got %0d want 0", occupancy); end
        n_vec++; if (alu_valid !== 1'b0) begin n_err++;
            $display("FAIL reset_valid: got %b want 0", alu_valid); end
        n_vec++; if (full !== 1'b0) begin n_err++;
            $display("FAIL reset_full: got %b want 0", full); end
        n_vec++; if (alu_vi !== 32'h0 || alu_rob !== 4'd0 || alu_imm !== 12'h0 || alu_op !== 1'b0) begin n_err++;
            $display("FAIL reset_payload: vi=%h rob=%0d imm=%h op=%b want all 0", alu_vi, alu_rob, alu_imm, alu_op); end
        #1 rst_in = 1'b1;
        tick();
        n_vec++; if (alu_valid !== 1'b0 || occupancy !== 4'd0) begin n_err++;
            $display("FAIL post_reset_idle: valid=%b occ=%0d want 0 0", alu_valid, occupancy); end
    endtask

    task automatic test_ready_dispatch();
        set_disp(1'b0, 12'h010, 1'b0, 4'd0, 32'h0000_1000, 4'd3);
        tick();
        idle();
        n_vec++; if (alu_valid !== 1'b0 || occupancy !== 4'd1) begin n_err++;
            $display("FAIL rd_edgeN: valid=%b occ=%0d want 0 1", alu_valid, occupancy); end
        tick();
        n_vec++; if (alu_valid !== 1'b1 || alu_vi !== 32'h0000_1000 || alu_imm !== 12'h010
                     || alu_rob !== 4'd3 || alu_op !== 1'b0) begin n_err++;
            $display("FAIL rd_issue: valid=%b vi=%h imm=%h rob=%0d op=%b want 1 00001000 010 3 0",
                     alu_valid, alu_vi, alu_imm, alu_rob, alu_op); end
        n_vec++; if (occupancy !== 4'd0) begin n_err++;
            $display("FAIL rd_occ: got %0d want 0", occupancy); end
        tick();
        n_vec++; if (alu_valid !== 1'b0 || alu_vi !== 32'h0000_1000) begin n_err++;
            $display("FAIL rd_after: valid=%b vi=%h want 0 00001000", alu_valid, alu_vi); end
    endtask

    task automatic test_wakeup_forward();
        set_disp(1'b1, 12'h020, 1'b1, 4'd5, 32'h0, 4'd6);
        tick();
        idle();
        cdb_valid = 1'b1; cdb_rob = 4'd4; cdb_value = 32'h1111_1111;
        tick();
        cdb_valid = 1'b0;
        tick();
        n_vec++; if (alu_valid !== 1'b0 || occupancy !== 4'd1) begin n_err++;
            $display("FAIL wk_waiting: valid=%b occ=%0d want 0 1", alu_valid, occupancy); end
        cdb_valid = 1'b1; cdb_rob = 4'd5; cdb_value = 32'h0000_DEAD;
        tick();
        cdb_valid = 1'b0;
        n_vec++; if (alu_valid !== 1'b0) begin n_err++;
            $display("FAIL wk_same_edge: got valid %b want 0", alu_valid); end
        tick();
        n_vec++; if (alu_valid !== 1'b1 || alu_vi !== 32'h0000_DEAD || alu_rob !== 4'd6
                     || alu_op !== 1'b1 || alu_imm !== 12'h020) begin n_err++;
            $display("FAIL wk_issue: valid=%b vi=%h rob=%0d op=%b imm=%h want 1 0000dead 6 1 020",
                     alu_valid, alu_vi, alu_rob, alu_op, alu_imm); end
        set_disp(1'b0, 12'h030, 1'b1, 4'd7, 32'h0, 4'd2);
        cdb_valid = 1'b1; cdb_rob = 4'd7; cdb_value = 32'h0000_BEEF;
        tick();
        idle();
        tick();
        n_vec++; if (alu_valid !== 1'b1 || alu_vi !== 32'h0000_BEEF || alu_rob !== 4'd2) begin n_err++;
            $display("FAIL fwd_issue: valid=%b vi=%h rob=%0d want 1 0000beef 2", alu_valid, alu_vi, alu_rob); end
        tick();
        n_vec++; if (alu_valid !== 1'b0 || occupancy !== 4'd0) begin n_err++;
            $display("FAIL fwd_drain: valid=%b occ=%0d want 0 0", alu_valid, occupancy); end
    endtask

    task automatic test_full_order();
        for (int i = 0; i < 8; i++) begin
            set_disp(1'(i % 2), 12'(i), 1'b1, (i == 2 || i == 6) ? 4'd4 : 4'(8 + i), 32'h0, 4'(i));
            tick();
        end
        n_vec++; if (full !== 1'b1 || occupancy !== 4'd8) begin n_err++;
            $display("FAIL fill: full=%b occ=%0d want 1 8", full, occupancy); end
        set_disp(1'b0, 12'hFFF, 1'b1, 4'd1, 32'h0, 4'd15);
        tick();
        idle();
        n_vec++; if (occupancy !== 4'd8 || alu_valid !== 1'b0) begin n_err++;
            $display("FAIL ninth_drop: occ=%0d valid=%b want 8 0", occupancy, alu_valid); end
        cdb_valid = 1'b1; cdb_rob = 4'd4; cdb_value = 32'h0000_1234;
        tick();
        cdb_valid = 1'b0;
        n_vec++; if (full !== 1'b1 || alu_valid !== 1'b0) begin n_err++;
            $display("FAIL wake_pair: full=%b valid=%b want 1 0", full, alu_valid); end
        tick();
        n_vec++; if (alu_valid !== 1'b1 || alu_rob !== 4'd2 || alu_vi !== 32'h0000_1234 || alu_imm !== 12'd2) begin n_err++;
            $display("FAIL order_first: valid=%b rob=%0d vi=%h imm=%h want 1 2 00001234 002",
                     alu_valid, alu_rob, alu_vi, alu_imm); end
        n_vec++; if (full !== 1'b0 || occupancy !== 4'd7) begin n_err++;
            $display("FAIL order_full_drop: full=%b occ=%0d want 0 7", full, occupancy); end
        tick();
        n_vec++; if (alu_valid !== 1'b1 || alu_rob !== 4'd6 || alu_op !== 1'b0 || occupancy !== 4'd6) begin n_err++;
            $display("FAIL order_second: valid=%b rob=%0d op=%b occ=%0d want 1 6 0 6",
                     alu_valid, alu_rob, alu_op, occupancy); end
        tick();
        n_vec++; if (alu_valid !== 1'b0 || alu_rob !== 4'd6) begin n_err++;
            $display("FAIL order_idle: valid=%b rob=%0d want 0 6", alu_valid, alu_rob); end
    endtask

    task automatic test_flush();
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        n_vec++; if (occupancy !== 4'd0 || full !== 1'b0) begin n_err++;
            $display("FAIL flush_empty: occ=%0d full=%b want 0 0", occupancy, full); end
        for (int i = 0; i < 4; i++) begin
            set_disp(1'b0, 12'h0, 1'b1, 4'd9, 32'h0, 4'(i));
            tick();
        end
        n_vec++; if (occupancy !== 4'd4) begin n_err++;
            $display("FAIL flush_fill: occ=%0d want 4", occupancy); end
        set_disp(1'b1, 12'h044, 1'b0, 4'd0, 32'h0000_4444, 4'd9);
        clear_in = 1'b1;
        tick();
        idle();
        n_vec++; if (occupancy !== 4'd0 || alu_valid !== 1'b0 || full !== 1'b0) begin n_err++;
            $display("FAIL flush_clear: occ=%0d valid=%b full=%b want 0 0 0", occupancy, alu_valid, full); end
        tick();
        n_vec++; if (alu_valid !== 1'b0 || occupancy !== 4'd0) begin n_err++;
            $display("FAIL flush_drop: valid=%b occ=%0d want 0 0", alu_valid, occupancy); end
    endtask

    task automatic test_stall();
        set_disp(1'b0, 12'h001, 1'b0, 4'd0, 32'h0000_0055, 4'd1);
        tick();
        set_disp(1'b1, 12'h002, 1'b0, 4'd0, 32'h0000_0066, 4'd2);
        tick();
        set_disp(1'b0, 12'h003, 1'b0, 4'd0, 32'h0000_0077, 4'd3);
        rdy_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_vec++; if (alu_valid !== 1'b1 || alu_vi !== 32'h0000_0055 || alu_rob !== 4'd1
                         || occupancy !== 4'd1) begin n_err++;
                $display("FAIL stall_hold%0d: valid=%b vi=%h rob=%0d occ=%0d want 1 00000055 1 1",
                         c, alu_valid, alu_vi, alu_rob, occupancy); end
        end
        idle();
        tick();
        n_vec++; if (alu_valid !== 1'b1 || alu_vi !== 32'h0000_0066 || alu_rob !== 4'd2
                     || alu_op !== 1'b1 || occupancy !== 4'd0) begin n_err++;
            $display("FAIL stall_resume: valid=%b vi=%h rob=%0d op=%b occ=%0d want 1 00000066 2 1 0",
                     alu_valid, alu_vi, alu_rob, alu_op, occupancy); end
        tick();
        n_vec++; if (alu_valid !== 1'b0) begin n_err++;
            $display("FAIL stall_drain: valid=%b want 0", alu_valid); end
    endtask

    initial begin
        idle();
        rst_in = 1'b0;
        #1;
        n_vec++; if (occupancy !== 4'd0 || alu_valid !== 1'b0 || full !== 1'b0) begin n_err++;
            $display("FAIL init_reset: occ=%0d valid=%b full=%b want 0 0 0", occupancy, alu_valid, full); end
        repeat (2) @(posedge clk_in);
        #2 rst_in = 1'b1;
        tick();
        test_reset();
        test_ready_dispatch();
        test_wakeup_forward();
        test_full_order();
        test_flush();
        test_stall();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/lsj_rs.md
# lsj_rs

Reservation station and issue scheduler for the load/store/jalr address ALU. Holds up to RS_SIZE dispatched LSJ micro-ops and captures the base-register operand from the CDB when it is broadcast. Each cycle it selects one operand-ready entry and issues it, registered, onto the address ALU's input bus (valid, vi, imm, op, rob_entry). Sits between the dispatch/decode stage and the address ALU; flushed by the ROB on misprediction.

## Interface
- RS_SIZE, 8, number of entries (power of two, 2..16)
- ROB_BIT, `ROB_BIT, width of ROB tags
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-low reset
- rdy_in  input  1  global ready; when low, all state and outputs hold
- clear_in  input  1  synchronous flush from ROB; empties the station
- disp_valid  input  1  dispatch request this cycle
- disp_op  input  1  1 = store/jalr, 0 = load
- disp_imm  input  12  raw immediate
- disp_qj_busy  input  1  base operand still pending
- disp_qj  input  ROB_BIT  ROB tag producing the base operand
- disp_vj  input  32  base operand value; valid when disp_qj_busy = 0
- disp_rob  input  ROB_BIT  ROB entry of this op
- full  output  1  no free entry (combinational from registered busy vector)
- cdb_valid  input  1  CDB broadcast valid
- cdb_rob  input  ROB_BIT  broadcasting ROB tag
- cdb_value  input  32  broadcast value
- alu_valid  output  1  issue to ALU this cycle (registered)
- alu_vi  output  32  base operand
- alu_imm  output  12  immediate
- alu_op  output  1  op bit
- alu_rob  output  ROB_BIT  ROB entry
- occupancy  output  $clog2(RS_SIZE)+1  number of busy entries (registered)

## Operation
- Per entry: busy, op, imm, qj_busy, qj, vj, rob.
- Event priority: reset > rdy_in low (full hold) > clear_in > normal.
- clear_in: all busy cleared, alu_valid <= 0, occupancy <= 0; a same-cycle dispatch is dropped.
- Dispatch: accepted iff disp_valid && !full. It is written to the lowest-index entry not busy in the pre-edge state. If disp_valid && full, the op is dropped; the sender must hold it.
- Same-cycle forwarding at dispatch: if disp_qj_busy && cdb_valid && cdb_rob == disp_qj, the entry is written with qj_busy = 0 and vj = cdb_value.
- Wakeup: every busy entry with qj_busy && qj == cdb_rob && cdb_valid takes qj_busy <= 0 and vj <= cdb_value.
- Ready entry = busy && !qj_busy, evaluated on pre-edge state. An entry woken this cycle becomes ready next cycle.
- Select: the lowest-index ready entry; fixed priority. On the edge it is freed (busy <= 0), its fields are copied to the alu_* registers, and alu_valid <= 1. With no ready entry, alu_valid <= 0 and the alu_* payload holds.
- A slot freed by issue is not reusable by a dispatch in the same cycle.
- occupancy updates by +1 (accepted dispatch), -1 (issue), or 0 (both, or neither).

## Timing
- Reset (async, rst_in = 0) sets: busy all 0, alu_valid 0, alu_vi 0, alu_imm 0, alu_op 0, alu_rob 0, occupancy 0, full 0.
- Dispatch with ready operand at edge N: issued at edge N+1, so alu_valid is high during cycle N+1..N+2.
- Dispatch waiting on a tag, CDB match at edge M: issued no earlier than edge M+1.
- Throughput: one issue per cycle.
- Dispatch and issue may occur on the same edge. full is combinational and therefore reflects only the pre-edge busy vector.
- rdy_in low: no dispatch is accepted, no wakeup, no issue; alu_valid and the payload hold their values. CDB broadcasts during the stall are not captured; upstream must also be stalled.

## Test plan
- Reset/idle: drive rst_in low mid-operation with 3 busy entries. Required: occupancy = 0, alu_valid = 0 asynchronously, full = 0.
- Ready dispatch: op = 0, vj = 0x1000, imm = 0x010, rob = 3 at edge N. Required: at N+1, alu_valid = 1, alu_vi = 0x1000, alu_imm = 0x010, alu_rob = 3; at N+2, alu_valid = 0.
- Wakeup and forward:
  - Dispatch with qj = 5 pending. At a later cycle drive cdb_rob = 5, cdb_value = 0xDEAD. Required: issue on the following edge with alu_vi = 0xDEAD.
  - Repeat with the CDB hit in the dispatch cycle itself. Required: issue one edge after dispatch.
- Full/ordering:
  - Fill 8 entries, all pending. Required: full = 1, and a 9th dispatch is dropped with occupancy still 8.
  - Wake tags for entries 6 and 2 together. Required: entry 2 issues, then entry 6; full drops after the first issue.
- Flush and stall:
  - Assert clear_in together with disp_valid while 4 entries are busy. Required: occupancy = 0 next cycle and nothing issues.
  - Hold rdy_in low for 3 cycles while an entry is ready. Required: alu_* holds its values and the entry issues on the first edge after rdy_in returns high.
